nrf_line_sequencer: RTL and testbench
=====================================

# nrf_line_sequencer

Streaming controller that owns the binary noise-rejection filter stage of the Sobel edge path. It accepts thresholded edge pixels from upstream and frames them into lines of IMG_WIDTH. It drives the filter's push strobe, inserts zero padding after every line so the 3-pixel window and its output history never leak across lines or frames, and discards filter outputs that belong to padding. Downstream receives exactly IMG_WIDTH×IMG_HEIGHT filtered pixels per frame, tagged with line and frame markers.

## Interface
- IMG_WIDTH, 640: active pixels per line (≥3).
- IMG_HEIGHT, 480: lines per frame (≥1).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  upstream ready; a transfer happens when s_valid && s_ready.
- s_pixel  in  1  binary edge pixel.
- s_sof  in  1  marks the first pixel of a frame.
- filt_pixel_valid  out  1  push strobe to the filter (registered).
- filt_pixel_in  out  1  pixel pushed to the filter (registered).
- filt_pixel_out  in  1  filter result; updates one edge after each push.
- m_valid  out  1  filtered pixel valid; no backpressure.
- m_pixel  out  1  filtered pixel.
- m_sol / m_eol  out  1  first / last pixel of a line (qualified by m_valid).
- m_sof / m_eof  out  1  first / last pixel of a frame (qualified by m_valid).
- sof_err  out  1  one-cycle pulse on a frame abort.
- busy  out  1  high from frame start until the last m_valid of that frame.
- stat_removed  out  clog2(IMG_WIDTH*IMG_HEIGHT+1)  only when NRF_SEQ_STATS_EN is defined.
- stat_valid  out  1  only when NRF_SEQ_STATS_EN is defined.
- The filter instance's reset is driven with ~rst by the integrator, so filter and sequencer come out of reset in the same cycle.

## Operation
- FSM states: IDLE, LINE, FLUSH, ABORT.
- IDLE:
  - s_ready=1.
  - Pixels without s_sof are accepted and dropped.
  - An accepted pixel with s_sof is pushed as column 0 of row 0; go to LINE; busy=1.
- LINE:
  - s_ready=1; each accepted pixel is pushed; col increments.
  - After the push of col IMG_WIDTH-1, go to FLUSH.
- FLUSH:
  - s_ready=0.
  - Push exactly 4 zeros, one per cycle. These clear the filter's window and its two-deep output history.
  - Then: if row==IMG_HEIGHT-1, go to IDLE; else increment row, clear col, go to LINE.
- Accepted s_sof in LINE (any column) or in row≠0:
  - Pixel is dropped; sof_err pulses.
  - Go to ABORT: push 4 zeros with all outputs suppressed, then IDLE.
  - In-flight outputs of the aborted frame are suppressed; no m_eof is issued for it.
- Push index k per line runs 0..IMG_WIDTH+3. The filter result produced by push k belongs to pixel k-2.
- Only results of pushes k = 2..IMG_WIDTH+1 are forwarded, as column k-2. Results of pushes 0, 1, IMG_WIDTH+2 and IMG_WIDTH+3 are discarded.
- A 2-stage tag pipeline (valid, col==0, col==W-1, row==0, row==H-1) travels alongside each push to align the flags.
- Reset values: all outputs 0, except s_ready=1 (IDLE). row and col are 0.

## Timing
- Pixel accepted at edge E0 → filt_pixel_valid/filt_pixel_in driven in the cycle after E0 → filter samples at E1.
- With continuous input, m_valid for pixel j appears after edge E0+4. That is 2 pushes of window lag + 1 filter register + 1 output register.
- Steady state: one pixel per cycle within a line. Each line costs IMG_WIDTH+4 cycles of input time.
- m_eol and m_eof are emitted during the FLUSH push stream. busy falls in the cycle after the m_eof cycle.
- An s_sof accepted in IDLE on the cycle after FLUSH exits is legal. In-flight tags of the previous frame still drain correctly.
- Synchronous rst mid-frame:
  - Outputs return to reset values on the next edge.
  - The tag pipeline is cleared, so no m_valid appears after reset.
  - The filter is cleared through its own reset.

## Configuration
- NRF_SEQ_STATS_EN defined:
  - Counts forwarded pixels whose pushed value was 1 but whose m_pixel is 0. The raw value comes from a local 2-deep history of pushed pixels.
  - At m_eof, stat_removed is updated and stat_valid pulses in the same cycle.
  - The counter clears at each frame start and on rst. ABORT produces no stat_valid.
- Not defined: stat ports and counter are absent; all other behaviour is identical.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=2. Frame of all 1s with continuous s_valid:
  - Response: 16 m_valid pixels, all 1.
  - m_sol at columns 0 and 8-of-stream, m_eol at the 8th and 16th, m_sof on the first, m_eof on the last.
  - s_ready low for 4 cycles after each line.
- Line 00100000 followed by line 00000000:
  - Response: all outputs 0; no isolated pixel survives.
  - stat_removed=1 with NRF_SEQ_STATS_EN.
- Line 01100000: outputs 01100000 within the line, exact column alignment, first m_valid 4 cycles after the first acceptance.
- Line ending 00000011 followed by line 10000000: column 0 of the second line outputs 0, proving the flush isolates lines.
- s_sof asserted at column 3 of row 0:
  - sof_err pulses once; no m_eof for that frame.
  - A new frame started 5 cycles later outputs correctly.
- rst held 1 cycle mid-line:
  - All outputs 0 on the next cycle; no stray m_valid.
  - The next s_sof frame is bit-exact with a run from cold reset.

Source files
------------

// File: rtl/nrf_line_sequencer.sv
// Line/frame sequencer around the binary noise-rejection filter: frames edge pixels into lines,
// pads each line with four zero pushes and realigns filter results with their line/frame tags.
// Optional removed-pixel statistics are built when NRF_SEQ_STATS_EN is defined.
`timescale 1ns/1ps
module nrf_line_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_pixel,
  input  logic       s_sof,
  output logic       filt_pixel_valid,
  output logic       filt_pixel_in,
  input  logic       filt_pixel_out,
  output logic       m_valid,
  output logic       m_pixel,
  output logic       m_sol,
  output logic       m_eol,
  output logic       m_sof,
  output logic       m_eof,
  output logic       sof_err,
  output logic       busy,
`ifdef NRF_SEQ_STATS_EN
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] stat_removed,
  output logic       stat_valid,
`endif
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LINE = 2'd1, FLUSH = 2'd2, ABORT = 2'd3} state_t;

  // Tag describing the pixel whose filter result a given push produces (pixel k-2 for push k).
  typedef struct packed {
    logic fwd;
    logic sol;
    logic eol;
    logic sof;
    logic eof;
    logic raw;
  } tag_t;

  localparam int KW = $clog2(IMG_WIDTH + 4);
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [KW-1:0] K_FIRST_OUT = KW'(2);
  localparam logic [KW-1:0] K_LAST_PIX  = KW'(IMG_WIDTH - 1);
  localparam logic [KW-1:0] K_LAST_OUT  = KW'(IMG_WIDTH + 1);
  localparam logic [KW-1:0] K_END       = KW'(IMG_WIDTH + 3);
  localparam logic [KW-1:0] K_ABORT_END = KW'(3);
  localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_HEIGHT - 1);

  state_t        state;
  logic [KW-1:0] k;
  logic [RW-1:0] row;
  logic [1:0]    hist;
  tag_t          ptag;
  tag_t          rtag;

  logic accept;
  logic frame_start;
  logic abort_now;
  logic out_fwd;
  logic push_en;
  logic push_val;
  tag_t push_tag;

  // Handshake: a pixel transfers on any rising edge where s_valid && s_ready; s_ready is a
  // pure decode of the state register, so it never depends on s_valid in the same cycle.
  assign s_ready     = (state == IDLE) || (state == LINE);
  assign accept      = s_valid && s_ready;
  assign frame_start = accept && s_sof && (state == IDLE);
  assign abort_now   = accept && s_sof && (state == LINE);
  assign out_fwd     = rtag.fwd && !abort_now;
  assign state_dbg   = state;

  function automatic tag_t make_tag(input logic [KW-1:0] kk, input logic [RW-1:0] rr,
                                    input logic raw);
    tag_t t;
    t.fwd = (kk >= K_FIRST_OUT) && (kk <= K_LAST_OUT);
    t.sol = (kk == K_FIRST_OUT);
    t.eol = (kk == K_LAST_OUT);
    t.sof = t.sol && (rr == '0);
    t.eof = t.eol && (rr == ROW_LAST);
    t.raw = raw;
    return t;
  endfunction

  always_comb begin
    push_en  = 1'b0;
    push_val = 1'b0;
    push_tag = '0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          push_en  = 1'b1;
          push_val = s_pixel;
          push_tag = make_tag('0, '0, hist[1]);
        end
      end
      LINE: begin
        if (accept && !s_sof) begin
          push_en  = 1'b1;
          push_val = s_pixel;
          push_tag = make_tag(k, row, hist[1]);
        end
      end
      FLUSH: begin
        push_en  = 1'b1;
        push_tag = make_tag(k, row, hist[1]);
      end
      default: begin
        push_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      k                <= '0;
      row              <= '0;
      hist             <= '0;
      ptag             <= '0;
      rtag             <= '0;
      filt_pixel_valid <= 1'b0;
      filt_pixel_in    <= 1'b0;
      m_valid          <= 1'b0;
      m_pixel          <= 1'b0;
      m_sol            <= 1'b0;
      m_eol            <= 1'b0;
      m_sof            <= 1'b0;
      m_eof            <= 1'b0;
      sof_err          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      filt_pixel_valid <= push_en;
      filt_pixel_in    <= push_val;
      ptag             <= push_tag;
      if (push_en) hist <= {hist[0], push_val};
      // The filter consumes the registered push on this edge; its result is valid next cycle.
      rtag    <= abort_now ? '0 : ptag;
      m_valid <= out_fwd;
      m_pixel <= out_fwd & filt_pixel_out;
      m_sol   <= out_fwd & rtag.sol;
      m_eol   <= out_fwd & rtag.eol;
      m_sof   <= out_fwd & rtag.sof;
      m_eof   <= out_fwd & rtag.eof;
      sof_err <= abort_now;
      if (m_valid && m_eof) busy <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= LINE;
            k     <= KW'(1);
            row   <= '0;
            busy  <= 1'b1;
          end
        end
        LINE: begin
          if (abort_now) begin
            state <= ABORT;
            k     <= '0;
            row   <= '0;
          end else if (accept) begin
            k <= k + KW'(1);
            if (k == K_LAST_PIX) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (k == K_END) begin
            k <= '0;
            if (row == ROW_LAST) begin
              state <= IDLE;
              row   <= '0;
            end else begin
              state <= LINE;
              row   <= row + RW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        default: begin
          if (k == K_ABORT_END) begin
            k     <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            k <= k + KW'(1);
          end
        end
      endcase
    end
  end

`ifdef NRF_SEQ_STATS_EN
  localparam int STAT_W = $clog2(IMG_WIDTH*IMG_HEIGHT+1);
  logic [STAT_W-1:0] removed_cnt;
  logic [STAT_W-1:0] removed_nxt;

  // A pixel counts as removed when it was pushed as 1 but the filter forwarded 0.
  assign removed_nxt = removed_cnt + STAT_W'(out_fwd && rtag.raw && !filt_pixel_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      removed_cnt  <= '0;
      stat_removed <= '0;
      stat_valid   <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (frame_start) removed_cnt <= '0;
      else             removed_cnt <= removed_nxt;
      if (out_fwd && rtag.eof) begin
        stat_removed <= removed_nxt;
        stat_valid   <= 1'b1;
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = rtag.raw;
`endif

endmodule

// File: tb/tb_nrf_line_sequencer.sv
// Bench for nrf_line_sequencer (8x2 image): filter model, randomized frames, scoreboard of
// expected output pixels built from the neighbour rule, monitor on m_valid.
`timescale 1ns/1ps
module tb_nrf_line_sequencer;
  localparam int W = 8;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_pixel = 1'b0, s_sof = 1'b0;
  logic s_ready, filt_pixel_valid, filt_pixel_in, filt_pixel_out;
  logic m_valid, m_pixel, m_sol, m_eol, m_sof, m_eof, sof_err, busy;
  logic [1:0] state_dbg;
`ifdef NRF_SEQ_STATS_EN
  logic [$clog2(W*H+1)-1:0] stat_removed;
  logic stat_valid;
`endif

  always #5 clk = ~clk;

  // Filter model: 3-pixel window, keep centre only if a neighbour is set, two-deep output history.
  logic [2:0] win;
  logic       fhist;
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0; fhist <= 1'b0; filt_pixel_out <= 1'b0;
    end else if (filt_pixel_valid) begin
      win            <= {win[1:0], filt_pixel_in};
      fhist          <= win[0] & (win[1] | filt_pixel_in);
      filt_pixel_out <= fhist;
    end
  end

  nrf_line_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .s_sof(s_sof), .filt_pixel_valid(filt_pixel_valid), .filt_pixel_in(filt_pixel_in),
    .filt_pixel_out(filt_pixel_out), .m_valid(m_valid), .m_pixel(m_pixel), .m_sol(m_sol),
    .m_eol(m_eol), .m_sof(m_sof), .m_eof(m_eof), .sof_err(sof_err), .busy(busy),
`ifdef NRF_SEQ_STATS_EN
    .stat_removed(stat_removed), .stat_valid(stat_valid),
`endif
    .state_dbg(state_dbg)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  int stat_q[$];
  logic [W-1:0] frm [H];
  int sof_cyc = 0, first_cyc = 0;
  bit first_seen = 0;
  int sof_err_cnt = 0, eof_cnt = 0, ready_low_cnt = 0, frames_expected = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop one expectation for every presented output pixel.
  always @(negedge clk) begin
    if (!rst) begin
      if (sof_err) sof_err_cnt++;
      if (!s_ready) ready_low_cnt++;
      if (m_valid) begin
        if (m_sof && !first_seen) begin first_seen = 1; first_cyc = cyc; end
        if (m_eof) eof_cnt++;
        check("m_valid_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          check("m_out{pix,sol,eol,sof,eof}", int'({m_pixel, m_sol, m_eol, m_sof, m_eof}),
                int'(exp_q.pop_front()));
      end
`ifdef NRF_SEQ_STATS_EN
      if (stat_valid) begin
        check("stat_valid_at_eof", int'(m_valid && m_eof), 1);
        check("stat_expected", int'(stat_q.size() > 0), 1);
        if (stat_q.size() > 0) check("stat_removed", int'(stat_removed), stat_q.pop_front());
      end
`endif
    end
  end

  function automatic bit px(input int r, input int c);
    if (c < 0 || c >= W) return 1'b0;
    return frm[r][W-1-c];
  endfunction

  // Reference: a pixel survives only if a horizontal neighbour in the same line is also set.
  task automatic model_frame();
    int removed = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        bit o;
        o = px(r, c) & (px(r, c-1) | px(r, c+1));
        exp_q.push_back({o, c == 0, c == W-1, r == 0 && c == 0, r == H-1 && c == W-1});
        removed += int'(px(r, c) & !o);
      end
    end
    stat_q.push_back(removed);
    frames_expected++;
  endtask

  task automatic send_px(input bit p, input bit sof, input int max_gap);
    int g, tmo;
    g = $urandom_range(0, max_gap);
    if (g > 0) begin s_valid = 1'b0; repeat (g) @(negedge clk); end
    s_valid = 1'b1; s_pixel = p; s_sof = sof; tmo = 0;
    while (!s_ready && tmo < 100) begin @(negedge clk); tmo++; end
    if (tmo >= 100) check("s_ready_timeout", tmo, 0);
    @(negedge clk);
    if (sof) sof_cyc = cyc;
    s_sof = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, input bit expect_it);
    if (expect_it) model_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(px(r, c), r == 0 && c == 0, max_gap);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int tmo = 0;
    while ((exp_q.size() > 0) && tmo < 200) begin @(negedge clk); tmo++; end
    check("drain_exp_q_empty", exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"}, int'(s_ready), 1);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_filt_valid"}, int'(filt_pixel_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_sof_err"}, int'(sof_err), 0);
    check({tag, "_state"}, int'(state_dbg), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int eof_before;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Non-sof pixels in IDLE are dropped.
    for (int i = 0; i < 3; i++) send_px(1'b1, 1'b0, 0);
    s_valid = 1'b0;
    check("idle_drop_no_push", int'(filt_pixel_valid), 0);

    // All ones, continuous: flush stalls and first-output latency.
    frm[0] = 8'hFF; frm[1] = 8'hFF;
    ready_low_cnt = 0; first_seen = 0;
    send_frame(0, 1);
    check("busy_during_frame", int'(busy), 1);
    drain();
    check("ready_low_cycles", ready_low_cnt, 4 * H);
    check("busy_after_frame", int'(busy), 0);
    check("latency_all_ones", first_cyc - sof_cyc, 4);

    // Isolated pixel removed.
    frm[0] = 8'b00100000; frm[1] = 8'b00000000;
    send_frame(0, 1); drain();

    // Pair survives with column alignment and four-cycle latency.
    frm[0] = 8'b01100000; frm[1] = 8'b00000000;
    first_seen = 0;
    send_frame(0, 1); drain();
    check("latency_pair", first_cyc - sof_cyc, 4);

    // Flush isolates consecutive lines.
    frm[0] = 8'b00000011; frm[1] = 8'b10000000;
    send_frame(0, 1); drain();

    // Frame abort on s_sof at column 3, then a new frame five cycles later.
    sof_err_cnt = 0; eof_before = eof_cnt;
    send_px(1'b1, 1'b1, 0); send_px(1'b1, 1'b0, 0); send_px(1'b1, 1'b0, 0);
    send_px(1'b1, 1'b1, 0);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_after_abort", int'(busy), 0);
    frm[0] = W'($urandom); frm[1] = W'($urandom);
    send_frame(0, 1); drain();
    check("sof_err_pulses", sof_err_cnt, 1);
    check("eof_after_abort", eof_cnt - eof_before, 1);

    // Back-to-back frames: second sof right after the flush exit.
    frm[0] = 8'b11011001; frm[1] = 8'b01110110;
    send_frame(0, 1);
    frm[0] = 8'b10110111; frm[1] = 8'b00011100;
    send_frame(0, 1);
    drain();

    // Synchronous reset mid-line, then the all-ones frame again.
    send_px(1'b1, 1'b1, 0); send_px(1'b1, 1'b0, 0); send_px(1'b1, 1'b0, 0);
    s_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    frm[0] = 8'hFF; frm[1] = 8'hFF;
    send_frame(0, 1); drain();

    // Randomized frames with random gaps and dropped idle pixels.
    for (int f = 0; f < 10; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) send_px(1'($urandom), 1'b0, 1);
      frm[0] = W'($urandom); frm[1] = W'($urandom);
      send_frame(2, 1);
    end
    s_valid = 1'b0;
    drain();

    check("eof_count", eof_cnt, frames_expected);
    check("exp_q_empty_end", exp_q.size(), 0);
`ifdef NRF_SEQ_STATS_EN
    check("stat_q_empty_end", stat_q.size(), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
